// File: rtl/parity_mem_writer_pkg.sv
// Shared definitions for the parity memory writer.
// - Geometry: DEPTH entries split across two BANK_DEPTH banks, ADDR_W-bit
//   address whose MSB selects the bank.
// - state_t: fill-level FSM encoding.
// - parity_of(): parity bit of a (zero-extended) data word.
package parity_mem_writer_pkg;

  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int BANK_DEPTH = 8;
  localparam int BANK_AW    = 3;
  localparam int CNT_W      = 5;   // must hold 0..DEPTH inclusive
  localparam int PAR_IN_W   = 64;  // widest data word parity_of() accepts

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Zero extension does not change XOR parity, so callers cast up to PAR_IN_W.
  function automatic logic parity_of(input logic [PAR_IN_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_mem_writer_if.sv
// Write channel of the parity memory writer.
// - wr_valid / wr_data / inject_err : driven by the source (master).
// - wr_ready                        : driven by the writer (slave).
interface parity_mem_writer_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              inject_err;

  modport master (output wr_valid, output wr_data, output inject_err, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  inject_err, output wr_ready);
endinterface

// File: rtl/parity_mem_writer_bank.sv
// parity_bank: BANK_DEPTH x (DATA_W+1) storage, {parity, data} per entry.
// Ports:
//   clock          falling-edge clock
//   reset          sync active-high; zeroes data, parity set to INIT_PAR
//   we/waddr/wdata/wpar  write port
//   raddr -> rdata/rpar  combinational read port
module parity_bank
  import parity_mem_writer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit INIT_PAR = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [BANK_AW-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wpar,
  input  logic [BANK_AW-1:0] raddr,
  output logic [DATA_W-1:0]  rdata,
  output logic               rpar
);

  logic [DATA_W:0] mem [BANK_DEPTH];

  // Reset initialises every entry so all-zero data reads back with clean parity.
  always_ff @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) mem[i] <= {INIT_PAR, {DATA_W{1'b0}}};
    end else if (we) begin
      mem[waddr] <= {wpar, wdata};
    end
  end

  assign {rpar, rdata} = mem[raddr];

endmodule

// File: rtl/parity_mem_writer.sv
// parity_mem_writer: stores accepted bytes plus a generated parity bit at an
// auto-incrementing address across two banks (address MSB = bank select).
// Ports:
//   clock, reset        falling-edge clock, sync active-high reset
//   wr (slave)          valid/ready write channel with parity fault injection
//   clear               restart pointer/count, contents kept
//   rd_addr -> rd_data/rd_parity   combinational read port
//   wr_ptr, count, full, done      fill status; done pulses after last write
module parity_mem_writer
  import parity_mem_writer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  parity_mem_writer_if.slave  wr,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_parity,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                done
);

  state_t state, state_n;
  logic   accept, last_wr, wr_par;

  logic [1:0][DATA_W-1:0] bank_rdata;
  logic [1:0]             bank_rpar;

  // Ready never looks at wr_valid, so the source can't form a comb loop.
  assign wr.wr_ready = (state != FULL) && !clear;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign last_wr     = (count == CNT_W'(DEPTH - 1));
  assign full        = (count == CNT_W'(DEPTH));
  assign wr_par      = parity_of(PAR_IN_W'(wr.wr_data), ODD_PARITY) ^ wr.inject_err;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = FILL;
      FILL:    if (accept && last_wr) state_n = FULL;
      FULL:    state_n = FULL;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(negedge clock) begin
    if (reset || clear) begin
      state  <= IDLE;
      wr_ptr <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      done  <= accept && last_wr;
      if (accept) begin
        // Pointer wraps to 0 on the last write; FULL then protects entry 0.
        wr_ptr <= wr_ptr + ADDR_W'(1);
        count  <= count + CNT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    parity_bank #(
      .DATA_W  (DATA_W),
      .INIT_PAR(ODD_PARITY)
    ) u_bank (
      .clock (clock),
      .reset (reset),
      .we    (accept && (wr_ptr[ADDR_W-1] == 1'(b))),
      .waddr (wr_ptr[BANK_AW-1:0]),
      .wdata (wr.wr_data),
      .wpar  (wr_par),
      .raddr (rd_addr[BANK_AW-1:0]),
      .rdata (bank_rdata[b]),
      .rpar  (bank_rpar[b])
    );
  end

  assign rd_data   = bank_rdata[rd_addr[ADDR_W-1]];
  assign rd_parity = bank_rpar[rd_addr[ADDR_W-1]];

endmodule

// File: tb/tb_parity_mem_writer.sv
// Bench for parity_mem_writer: reference model (arrays + counters), expected
// writes queued by the driver and popped by an independent monitor.
module tb_parity_mem_writer;
  localparam bit ODD = 1'b0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_parity;
  logic [3:0] wr_ptr;
  logic [4:0] count;
  logic       full, done;

  parity_mem_writer_if #(.DATA_W(8)) wr_bus ();

  parity_mem_writer #(.DATA_W(8), .DEPTH(16), .ODD_PARITY(ODD)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr       (wr_bus),
    .clear    (clear),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_parity(rd_parity),
    .wr_ptr   (wr_ptr),
    .count    (count),
    .full     (full),
    .done     (done)
  );

  always #50 clock = ~clock;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [16];
  logic       m_par [16];
  int         m_count, m_ptr;

  function automatic logic exp_par(input logic [7:0] d, input logic inj);
    return (($countones(d) % 2) == 1) ^ ODD ^ inj;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 8'h00;
      m_par[i] = ODD;
    end
    m_count = 0;
    m_ptr   = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wr_bus.wr_valid = 1'b0;
    wr_bus.inject_err = 1'b0;
    clear = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; the model decides whether the write is taken.
  task automatic step(input logic v, input logic [7:0] d, input logic inj, input logic clr);
    bit acc;
    wr_bus.wr_valid   = v;
    wr_bus.wr_data    = d;
    wr_bus.inject_err = inj;
    clear             = clr;
    acc = v && !clr && (m_count < 16);
    if (clr) begin
      m_count = 0;
      m_ptr   = 0;
    end else if (acc) begin
      q.push_back('{addr: 4'(m_ptr), data: d});
      m_mem[m_ptr] = d;
      m_par[m_ptr] = exp_par(d, inj);
      m_ptr = (m_ptr + 1) % 16;
      m_count++;
    end
    tick();
    wr_bus.wr_valid   = 1'b0;
    wr_bus.inject_err = 1'b0;
    clear             = 1'b0;
    check("done", 32'(done), 32'(acc && (m_count == 16)));
    check("count", 32'(count), 32'(m_count));
  endtask

  task automatic check_status();
    #1;
    check("wr_ready", 32'(wr_bus.wr_ready), 32'(m_count < 16));
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == 16));
    check("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
  endtask

  task automatic check_mem();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(m_mem[a]));
      check($sformatf("rd_parity[%0d]", a), 32'(rd_parity), 32'(m_par[a]));
    end
  endtask

  task automatic read_const(input logic [3:0] a, input logic [7:0] d, input logic p);
    rd_addr = a;
    #1;
    check($sformatf("const_data[%0d]", a), 32'(rd_data), 32'(d));
    check($sformatf("const_par[%0d]", a), 32'(rd_parity), 32'(p));
  endtask

  // Monitor: mid-cycle, every handshake that will be taken must match the queue.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset && wr_bus.wr_valid && wr_bus.wr_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got ptr=%0h data=%0h exp no write", wr_ptr, wr_bus.wr_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wr_addr", 32'(wr_ptr), 32'(e.addr));
          check("wr_data", 32'(wr_bus.wr_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_bus.wr_valid   = 1'b0;
    wr_bus.wr_data    = 8'h00;
    wr_bus.inject_err = 1'b0;

    // 1: reset state
    do_reset(2);
    check_status();
    check("done_rst", 32'(done), 32'(0));
    check_mem();

    // 2: two writes, known parity
    step(1'b1, 8'h1F, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    read_const(4'd0, 8'h1F, 1'b1);
    read_const(4'd1, 8'h22, 1'b0);
    check_status();

    // random traffic with occasional clear and fault injection
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 19) == 0));
    end
    check_status();
    check_mem();

    // 3: fill 00..0F back to back, then hammer while full
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check_status();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b0, 1'b0);
    read_const(4'd0, 8'h00, ODD);
    check_status();
    check_mem();

    // 4: injected parity error at address 8 (bank 1)
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 8'h31, 1'b1, 1'b0);
    read_const(4'd8, 8'h31, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check_status();
    check_mem();

    // 5: clear out of FULL, five writes, then clear racing a write
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_status();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    clear = 1'b1;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_data = 8'h77;
    #1;
    check("ready_in_clear", 32'(wr_bus.wr_ready), 32'(0));
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check_status();
    check_mem();
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check_status();
    check_mem();

    // 6: reset at count 7, with a write pending (reset wins)
    do_reset(1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check_status();
    reset = 1'b1;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_data = 8'($urandom);
    tick();
    reset = 1'b0;
    wr_bus.wr_valid = 1'b0;
    model_reset();
    check("done_after_rst", 32'(done), 32'(0));
    check_status();
    check_mem();

    tick();
    check("queue_empty", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
